// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shifter.
// Mode codes and FSM state encodings.
package shift_pkg;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One-position shift/rotate step.
// Pure combinational; the FSM in seq_shifter iterates it.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_acc,
    output logic             bit_out
);

    // Select the single-bit move for the captured mode
    always_comb begin
        next_acc = acc;
        bit_out  = 1'b0;
        unique case (mode)
            MODE_SLL: begin
                next_acc = {acc[WIDTH-2:0], 1'b0};
                bit_out  = acc[WIDTH-1];
            end
            MODE_SRL: begin
                next_acc = {1'b0, acc[WIDTH-1:1]};
                bit_out  = acc[0];
            end
            MODE_SRA: begin
                next_acc = {acc[WIDTH-1], acc[WIDTH-1:1]};
                bit_out  = acc[0];
            end
            MODE_ROL: begin
                next_acc = {acc[WIDTH-2:0], acc[WIDTH-1]};
                bit_out  = acc[WIDTH-1];
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit position per clock.
// IDLE -> SHIFT (shamt steps) -> DONE pulse -> IDLE.
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         mode,
    output logic [WIDTH-1:0]   result,
    output logic               carry_out,
    output logic               busy,
    output logic               done
);

    localparam logic [SHAMT_W-1:0] CNT_ONE  = 1;
    localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         md_q, md_d;
    logic               carry_q, carry_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   step_acc;
    logic               step_bit;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc_q),
        .mode     (md_q),
        .next_acc (step_acc),
        .bit_out  (step_bit)
    );

    // Next-state: capture on start, iterate while cnt!=0, then pulse done
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        md_d    = md_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = data_in;
                    cnt_d   = shamt;
                    md_d    = mode;
                    carry_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != CNT_ZERO) begin
                    acc_d   = step_acc;
                    carry_d = step_bit;
                    cnt_d   = cnt_q - CNT_ONE;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            md_q    <= MODE_SLL;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            md_q    <= md_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign result    = acc_q;
    assign carry_out = carry_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter.
// Vector table plus hand sequences for handshake/reset corners.
module tb_seq_shifter;
    import shift_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] data_in;
    logic [3:0]  shamt;
    logic [1:0]  mode;
    logic [11:0] result;
    logic        carry_out;
    logic        busy;
    logic        done;

    int n_cmp;
    int n_err;

    seq_shifter #(
        .WIDTH   (12),
        .SHAMT_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .data_in   (data_in),
        .shamt     (shamt),
        .mode      (mode),
        .result    (result),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] din;
        logic [3:0]  sh;
        logic [1:0]  md;
        logic [11:0] res;
        logic        cy;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one operation from IDLE and check result, carry, latency
    task automatic run_op(input logic [11:0] din, input logic [3:0] sh,
                          input logic [1:0] md, input logic [11:0] er,
                          input logic ec, input string tag);
        int edges;
        @(negedge clk);
        start   = 1'b1;
        data_in = din;
        shamt   = sh;
        mode    = md;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 1;
        chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, " done_seen"}, 32'(done), 32'd1);
        chk({tag, " latency"}, 32'(edges), 32'(sh) + 32'd2);
        chk({tag, " result"}, 32'(result), 32'(er));
        chk({tag, " carry"}, 32'(carry_out), 32'(ec));
        @(posedge clk);
        #1;
        chk({tag, " done_drop"}, 32'(done), 32'd0);
        chk({tag, " busy_drop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        shamt   = '0;
        mode    = MODE_SLL;

        vecs[0]  = '{12'h801, 4'd1,  MODE_SLL, 12'h002, 1'b1};
        vecs[1]  = '{12'h8F0, 4'd4,  MODE_SRA, 12'hF8F, 1'b0};
        vecs[2]  = '{12'h8F0, 4'd4,  MODE_SRL, 12'h08F, 1'b0};
        vecs[3]  = '{12'h801, 4'd13, MODE_ROL, 12'h003, 1'b1};
        vecs[4]  = '{12'h0A5, 4'd15, MODE_SLL, 12'h000, 1'b0};
        vecs[5]  = '{12'hABC, 4'd0,  MODE_SLL, 12'hABC, 1'b0};
        vecs[6]  = '{12'h800, 4'd12, MODE_SRA, 12'hFFF, 1'b1};
        vecs[7]  = '{12'hFFF, 4'd12, MODE_SRL, 12'h000, 1'b1};
        vecs[8]  = '{12'hFFF, 4'd13, MODE_SLL, 12'h000, 1'b0};
        vecs[9]  = '{12'h123, 4'd4,  MODE_ROL, 12'h231, 1'b1};
        vecs[10] = '{12'h7F0, 4'd15, MODE_SRA, 12'h000, 1'b0};
        vecs[11] = '{12'h001, 4'd1,  MODE_SRL, 12'h000, 1'b1};

        #12;
        chk("reset result", 32'(result), 32'd0);
        chk("reset carry", 32'(carry_out), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].din, vecs[i].sh, vecs[i].md,
                   vecs[i].res, vecs[i].cy, $sformatf("vec%0d", i));
        end

        // Result holds in IDLE while inputs wander with start low
        data_in = 12'h555;
        shamt   = 4'd7;
        mode    = MODE_ROL;
        repeat (3) @(posedge clk);
        #1;
        chk("idle hold result", 32'(result), 32'h000);
        chk("idle hold carry", 32'(carry_out), 32'd1);
        chk("idle no done", 32'(done), 32'd0);

        // Start held high: done on edges 2,5,8,11 after first acceptance
        @(negedge clk);
        start   = 1'b1;
        data_in = 12'hABC;
        shamt   = 4'd0;
        mode    = MODE_SLL;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("held start done e%0d", e), 32'(done),
                32'((e % 3) == 2));
        end
        chk("held start result", 32'(result), 32'hABC);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Busy protection: second start while busy is ignored
        @(negedge clk);
        start   = 1'b1;
        data_in = 12'h00F;
        shamt   = 4'd3;
        mode    = MODE_SLL;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start   = 1'b1;
        data_in = 12'hFFF;
        shamt   = 4'd9;
        mode    = MODE_SRA;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("busy prot done", 32'(done), 32'd1);
        chk("busy prot result", 32'(result), 32'h078);
        chk("busy prot carry", 32'(carry_out), 32'd0);
        for (int e = 0; e < 5; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("busy prot no queue %0d", e), 32'(done | busy),
                32'd0);
        end

        // Reset mid-operation
        @(negedge clk);
        start   = 1'b1;
        data_in = 12'hABC;
        shamt   = 4'd10;
        mode    = MODE_SRL;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre reset busy", 32'(busy), 32'd1);
        chk("pre reset result", 32'(result), 32'h157);
        rst_n = 1'b0;
        #1;
        chk("mid reset result", 32'(result), 32'd0);
        chk("mid reset carry", 32'(carry_out), 32'd0);
        chk("mid reset busy", 32'(busy), 32'd0);
        chk("mid reset done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post reset idle %0d", e), 32'(done | busy),
                32'd0);
        end
        run_op(12'hABC, 4'd3, MODE_SRL, 12'h157, 1'b1, "after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
